seq_shift_unit_32: RTL and testbench
====================================

// Module: seq_shift_unit_32
// PURPOSE
//   Multi-cycle 32-bit shift/rotate unit feeding the shift-result input of the
//   multifunctional ALU result mux.
//   - Accepts an operand, a shift amount and an opcode on a start pulse.
//   - Shifts one bit position per clock, then presents the result with a one-cycle done pulse.
//   - Frees the single-cycle ALU datapath from a full barrel shifter.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   SHW    5   shift-amount width; must equal clog2(WIDTH)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      synchronous reset, active low
//   start  in   1      request; sampled only in IDLE
//   op     in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   a      in   WIDTH  operand, captured when start is accepted
//   shamt  in   SHW    shift amount 0..WIDTH-1, captured when start is accepted
//   busy   out  1      high in SHIFT and FIN
//   done   out  1      one-cycle pulse, high in FIN
//   f      out  WIDTH  result register
//   zf     out  1      high when f == 0
// BEHAVIOUR
//   Reset (rst_n=0 at a rising edge)
//     - state=IDLE; busy=0, done=0, f=0, zf=1.
//     - Internal work register and counter are cleared.
//     - Reset wins over everything, including mid-operation; the partial result is discarded.
//   States and transitions
//     - IDLE:  edge with start=1 latches work<=a, cnt<=shamt, opr<=op.
//              Next state is SHIFT if shamt!=0, otherwise FIN with f<=a.
//              With start=0, stays in IDLE and holds f.
//     - SHIFT: each edge shifts work by one position and decrements cnt.
//              On the edge where cnt==1, f<=the shifted value and the next state is FIN.
//     - FIN:   done=1 for exactly one cycle, then IDLE on the next edge.
//   Handshake
//     - start is ignored while busy=1, including in FIN; no queuing.
//     - a, shamt and op may change freely after the accepting edge.
//     - Earliest back-to-back accept is in the first IDLE cycle after FIN.
//   Latency
//     - Counted from the accepting edge, done is visible after max(N,1) further edges, N=shamt.
//     - The accepting edge is followed by N shift edges; for N=0 a single edge loads f.
//   f
//     - Updated only on the edge that enters FIN.
//     - Holds its value through IDLE and the next SHIFT until the new result lands.
//     - zf is combinational from f.
//   Per-step arithmetic, WIDTH bits, no carry out
//     - SLL: {w[W-2:0],1'b0}
//     - SRL: {1'b0,w[W-1:1]}
//     - SRA: {w[W-1],w[W-1:1]}
//     - ROL: {w[W-2:0],w[W-1]}
//   Boundaries
//     - shamt=WIDTH-1 is the maximum and takes 31 shift edges.
//     - SRA of a negative operand saturates to all ones.
//     - ROL by 0 returns a unchanged.
// TESTING
//   1. SLL a=0x0000_0001, shamt=4 -> done after 4 edges, f=0x0000_0010, zf=0, busy=1 for 5 cycles.
//   2. SRA a=0x8000_0000, shamt=31 -> f=0xFFFF_FFFF after 31 edges.
//      SRL of the same operand and shamt -> f=0x0000_0001.
//   3. ROL a=0x8000_0001, shamt=1 -> f=0x0000_0003.
//      SRL a=0x0000_0001, shamt=1 -> f=0, zf=1.
//   4. shamt=0, SLL a=0x1234_5678 -> done after 1 edge, f=0x1234_5678.
//      start held high through FIN -> second op starts only in the following IDLE cycle.
//   5. start pulsed mid-SHIFT with new a/shamt -> ignored, result matches the first request.
//      rst_n=0 mid-SHIFT -> next cycle busy=0, done=0, f=0, zf=1.

Source files
------------

// File: rtl/seq_shift_unit_32.sv
// Multi-cycle shift/rotate unit: one bit position per clock,
// result register f with a one-cycle done pulse on completion.
module seq_shift_unit_32 #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             zf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       opr_q, opr_d;
    logic [WIDTH-1:0] step;

    always_comb begin
        step = work_q;
        unique case (opr_q)
            OP_SLL: step = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL: step = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OP_ROL: step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default: step = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = a;
                    cnt_d  = shamt;
                    opr_d  = op;
                    if (shamt == '0) begin
                        f_d     = a;
                        state_d = FIN;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - CNT_ONE;
                // last step: result lands in f as FIN is entered
                if (cnt_q == CNT_ONE) begin
                    f_d     = step;
                    state_d = FIN;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            opr_q   <= OP_SLL;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
        end
    end

    assign busy = (state_q == SHIFT) || (state_q == FIN);
    assign done = (state_q == FIN);
    assign f    = f_q;
    assign zf   = (f_q == '0);

endmodule

// File: tb/tb_seq_shift_unit_32.sv
// Scoreboard bench for seq_shift_unit_32: directed vectors,
// expected results queued at issue and checked on each done pulse.
module tb_seq_shift_unit_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] f;
    logic        zf;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    seq_shift_unit_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .zf    (zf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got f=%h expected no result", f);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("result_f", f, e);
                check("result_zf", {31'd0, zf}, {31'd0, (e == 32'd0)});
            end
        end
    end

    task automatic wait_done(output int bc, output bit got);
        bc  = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] av,
                       input logic [4:0] n, input logic [31:0] ef);
        int bc;
        bit got;
        @(negedge clk);
        op = o; a = av; shamt = n; start = 1'b1;
        exp_q.push_back(ef);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF; shamt = 5'd7; op = ~o;
        wait_done(bc, got);
        check("busy_cycles", 32'(bc), (n == 5'd0) ? 32'd1 : 32'(n) + 32'd1);
        @(posedge clk);
    endtask

    initial begin
        int bc;
        bit got;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_f", f, 32'd0);
        check("rst_zf", {31'd0, zf}, 32'd1);
        rst_n = 1'b1;

        run(2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010);
        run(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run(2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003);
        run(2'b01, 32'h0000_0001, 5'd1,  32'h0000_0000);
        run(2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678);
        run(2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678);
        run(2'b11, 32'h1234_5678, 5'd4,  32'h2345_6781);
        run(2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000);
        run(2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000);
        run(2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);

        // start held high through FIN
        @(negedge clk);
        op = 2'b00; a = 32'h1234_5678; shamt = 5'd0; start = 1'b1;
        exp_q.push_back(32'h1234_5678);
        @(posedge clk);
        #1;
        a = 32'h0000_0003; shamt = 5'd2;
        exp_q.push_back(32'h0000_000C);
        @(negedge clk);
        check("hold_fin_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("hold_idle_busy", {31'd0, busy}, 32'd0);
        check("hold_f_held", f, 32'h1234_5678);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("hold_accept_busy", {31'd0, busy}, 32'd1);
        wait_done(bc, got);
        @(posedge clk);

        // start pulsed mid-SHIFT is ignored
        @(negedge clk);
        op = 2'b00; a = 32'h0000_0001; shamt = 5'd8; start = 1'b1;
        exp_q.push_back(32'h0000_0100);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFF; shamt = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(bc, got);
        check("midstart_busy", 32'(bc), 32'd7);
        @(posedge clk);

        // reset mid-SHIFT discards the operation
        @(negedge clk);
        op = 2'b00; a = 32'h0000_0005; shamt = 5'd10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_f", f, 32'd0);
        check("midrst_zf", {31'd0, zf}, 32'd1);
        rst_n = 1'b1;

        run(2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
